// File: rtl/buffer_tra_spi_data.sv
// Transmit buffer: unpacks one 76-bit request frame and feeds the SPI master byte by byte.
// Optional WAIT timeout is enabled by defining BUFFER_TRA_TIMEOUT_EN.
module buffer_tra_spi_data #(
    parameter int MAX_BYTES      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [75:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [7:0]  spi_id_out,
    output logic [7:0]  spi_select_out,
    output logic [7:0]  spi_data_out,
    output logic [4:0]  addr,
    output logic        spi_start,
    input  logic        spi_done,
    output logic        busy,
    output logic        tx_done,
    output logic        tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] MAX_N = 3'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [47:0] pay_q, pay_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  addr_q, addr_d;
    logic [4:0]  idx_q, idx_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [4:0]  idx_inc;
    logic        n_bad;
    logic        last_byte;

`ifdef BUFFER_TRA_TIMEOUT_EN
    localparam int          CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_ok;

    assign unused_ok = ^frame_in[8:0];
`else
    logic unused_ok;

    assign unused_ok = ^{frame_in[8:0], (TIMEOUT_CYCLES != 0)};
`endif

    // Byte slot 2 is the register byte, slots 3..7 the payload b3..b7.
    function automatic logic [7:0] byte_at(input logic [4:0] i, input logic [47:0] p);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            5'd2:    b = p[47:40];
            5'd3:    b = p[39:32];
            5'd4:    b = p[31:24];
            5'd5:    b = p[23:16];
            5'd6:    b = p[15:8];
            5'd7:    b = p[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign idx_inc   = idx_q + 5'd1;
    assign n_bad     = (n_q == 3'd0) || (n_q > MAX_N);
    assign last_byte = (idx_q == (5'd2 + {2'b00, n_q}));

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        n_d     = n_q;
        id_d    = id_q;
        sel_d   = sel_q;
        data_d  = data_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
`ifdef BUFFER_TRA_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    id_d    = frame_in[75:68];
                    sel_d   = frame_in[67:60];
                    pay_d   = frame_in[59:12];
                    n_d     = frame_in[11:9];
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (n_bad) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    idx_d   = 5'd2;
                    addr_d  = 5'd2;
                    data_d  = byte_at(5'd2, pay_q);
                    start_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (spi_done) begin
                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
`ifdef BUFFER_TRA_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
`endif
            end
            // Gap cycle so each new start trails the previous spi_done by two cycles.
            S_NEXT: begin
                idx_d   = idx_inc;
                addr_d  = idx_inc;
                data_d  = byte_at(idx_inc, pay_q);
                start_d = 1'b1;
                state_d = S_SEND;
            end
            S_DONE, S_ERR: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef BUFFER_TRA_TIMEOUT_EN
        if (start_d) begin
            cnt_d = '0;
        end else if (state_q == S_SEND || state_q == S_WAIT) begin
            cnt_d = cnt_q + CW'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pay_q   <= '0;
            n_q     <= '0;
            id_q    <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef BUFFER_TRA_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            n_q     <= n_d;
            id_q    <= id_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef BUFFER_TRA_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign frame_ready    = ready_q;
    assign spi_id_out     = id_q;
    assign spi_select_out = sel_q;
    assign spi_data_out   = data_q;
    assign addr           = addr_q;
    assign spi_start      = start_q;
    assign busy           = busy_q;
    assign tx_done        = done_q;
    assign tx_err         = err_q;

endmodule
